// File: rtl/rr_lock_arb_dir1_if.sv
// Request/grant bundle between requesters and the locked round-robin arbiter.
interface rr_lock_arb_dir1_if #(
  parameter int N = 8
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic          en;
  logic          done;
  logic [N-1:0]  gnt;
  logic          gnt_valid;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] ptr;
  logic          timeout;

  modport master (
    output req, en, done,
    input  gnt, gnt_valid, gnt_idx, ptr, timeout
  );

  modport slave (
    input  req, en, done,
    output gnt, gnt_valid, gnt_idx, ptr, timeout
  );
endinterface

// File: rtl/rr_lock_arb_dir1.sv
// Round-robin arbiter, descending-index search, grants locked until done or MAX_HOLD.
// Grant 1 cycle after request; owner keeps the grant regardless of req/en; no bubble on re-grant.
module rr_lock_arb_dir1 #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input logic               clock,
  input logic               reset,
  rr_lock_arb_dir1_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);
  localparam logic [HW-1:0] CNT_ONE = HW'(1);
  localparam logic [HW-1:0] CNT_MAX = HW'(MAX_HOLD);
  localparam logic [N-1:0]  GNT_LSB = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, LOCK} state_t;

  state_t        r_state;
  logic [N-1:0]  r_gnt;
  logic          r_gnt_valid;
  logic [IW-1:0] r_gnt_idx;
  logic [IW-1:0] r_ptr;
  logic          r_timeout;
  logic [HW-1:0] r_hold_cnt;

  logic          w_limit;
  logic          w_release;
  logic          w_arb;
  logic [IW-1:0] w_base;
  logic [IW-1:0] w_cand;
  logic [IW-1:0] w_win_idx;
  logic          w_win_found;

  assign w_limit   = (r_hold_cnt == CNT_MAX);
  assign w_release = (r_state == LOCK) && (bus.done || w_limit);
  // On release the search starts just below the outgoing owner, making it lowest priority.
  assign w_base    = (r_state == LOCK) ? (r_gnt_idx - IDX_ONE) : r_ptr;
  assign w_arb     = bus.en && (|bus.req) && ((r_state == IDLE) || w_release);

  // N is a power of 2, so IW-bit subtraction wraps modulo N.
  always_comb begin
    w_cand      = '0;
    w_win_idx   = '0;
    w_win_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_cand = w_base - IW'(k);
      if (!w_win_found && bus.req[w_cand]) begin
        w_win_idx   = w_cand;
        w_win_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_idx   <= '0;
      r_ptr       <= IW'(N - 1);
      r_timeout   <= 1'b0;
      r_hold_cnt  <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_arb) begin
            r_state     <= LOCK;
            r_gnt       <= GNT_LSB << w_win_idx;
            r_gnt_valid <= 1'b1;
            r_gnt_idx   <= w_win_idx;
            r_hold_cnt  <= CNT_ONE;
          end
        end
        LOCK: begin
          if (w_release) begin
            r_ptr     <= w_base;
            r_timeout <= !bus.done;
            if (w_arb) begin
              r_gnt       <= GNT_LSB << w_win_idx;
              r_gnt_valid <= 1'b1;
              r_gnt_idx   <= w_win_idx;
              r_hold_cnt  <= CNT_ONE;
            end else begin
              r_state     <= IDLE;
              r_gnt       <= '0;
              r_gnt_valid <= 1'b0;
              r_gnt_idx   <= '0;
              r_hold_cnt  <= '0;
            end
          end else if (!w_limit) begin
            r_hold_cnt <= r_hold_cnt + CNT_ONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.gnt_idx   = r_gnt_idx;
  assign bus.ptr       = r_ptr;
  assign bus.timeout   = r_timeout;
endmodule

// File: tb/tb_rr_lock_arb_dir1.sv
// Directed + random bench for rr_lock_arb_dir1 (N=8, MAX_HOLD=16) with a queue scoreboard.
module tb_rr_lock_arb_dir1;
  localparam int N        = 8;
  localparam int MAX_HOLD = 16;

  typedef struct packed {
    logic [7:0] gnt;
    logic       vld;
    logic [2:0] idx;
    logic [2:0] ptr;
    logic       to;
  } exp_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  // Reference model state
  bit m_lock;
  int m_idx;
  int m_ptr;
  int m_hold;
  bit m_to;

  rr_lock_arb_dir1_if #(.N(N)) bus ();

  rr_lock_arb_dir1 #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input int base, input logic [7:0] r);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (base - k + N) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [2:0] onehot2idx(input logic [7:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < N; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  task automatic model_reset();
    m_lock = 0; m_idx = 0; m_ptr = N - 1; m_hold = 0; m_to = 0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic e, input logic d);
    int base;
    m_to = 0;
    if (!m_lock) begin
      if (e && r != 0) begin
        m_lock = 1; m_idx = winner(m_ptr, r); m_hold = 1;
      end
    end else if (d || m_hold == MAX_HOLD) begin
      base  = (m_idx + N - 1) % N;
      m_ptr = base;
      m_to  = !d;
      if (e && r != 0) begin
        m_idx = winner(base, r); m_hold = 1;
      end else begin
        m_lock = 0; m_idx = 0; m_hold = 0;
      end
    end else if (m_hold < MAX_HOLD) begin
      m_hold++;
    end
  endtask

  task automatic step(input logic [7:0] r, input logic e, input logic d);
    exp_t ex;
    exp_t got;
    bus.req = r; bus.en = e; bus.done = d;
    model_step(r, e, d);
    ex.gnt = 8'h00;
    if (m_lock) ex.gnt[m_idx] = 1'b1;
    ex.vld = m_lock;
    ex.idx = 3'(m_idx);
    ex.ptr = 3'(m_ptr);
    ex.to  = m_to;
    sb_q.push_back(ex);
    @(posedge clock);
    #1;
    got = {bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.ptr, bus.timeout};
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      ex = sb_q.pop_front();
      chk("sb_gnt", 32'(got.gnt), 32'(ex.gnt));
      chk("sb_gnt_valid", 32'(got.vld), 32'(ex.vld));
      chk("sb_gnt_idx", 32'(got.idx), 32'(ex.idx));
      chk("sb_ptr", 32'(got.ptr), 32'(ex.ptr));
      chk("sb_timeout", 32'(got.to), 32'(ex.to));
    end
    chk("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
    chk("idx_consistent", 32'(bus.gnt_idx), 32'(onehot2idx(bus.gnt)));
    chk("valid_eq_or", 32'(bus.gnt_valid), 32'(|bus.gnt));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.req = '0; bus.en = 1'b0; bus.done = 1'b0;
    model_reset();
    #12;
    reset = 1'b0;
    chk("rst_gnt", 32'(bus.gnt), 32'h00);
    chk("rst_gnt_valid", 32'(bus.gnt_valid), 32'd0);
    chk("rst_gnt_idx", 32'(bus.gnt_idx), 32'd0);
    chk("rst_ptr", 32'(bus.ptr), 32'd7);
    chk("rst_timeout", 32'(bus.timeout), 32'd0);

    // 1: first grant from ptr=7
    step(8'b0000_0101, 1'b1, 1'b0);
    chk("t1_gnt", 32'(bus.gnt), 32'h04);
    chk("t1_idx", 32'(bus.gnt_idx), 32'd2);
    chk("t1_ptr", 32'(bus.ptr), 32'd7);

    // 2: done on third LOCK cycle, back-to-back grant to 7
    step(8'b1000_0100, 1'b1, 1'b0);
    step(8'b1000_0100, 1'b1, 1'b0);
    chk("t2_hold_gnt", 32'(bus.gnt), 32'h04);
    step(8'b1000_0100, 1'b1, 1'b1);
    chk("t2_gnt", 32'(bus.gnt), 32'h80);
    chk("t2_ptr", 32'(bus.ptr), 32'd1);
    chk("t2_no_gap", 32'(bus.gnt_valid), 32'd1);

    // 3: grant 0, release wraps ptr to 7, lone requester 0 re-granted
    step(8'b0000_0001, 1'b1, 1'b1);
    chk("t3_gnt0", 32'(bus.gnt), 32'h01);
    step(8'b0000_0001, 1'b1, 1'b1);
    chk("t3_wrap_ptr", 32'(bus.ptr), 32'd7);
    chk("t3_regrant", 32'(bus.gnt), 32'h01);
    step(8'h00, 1'b1, 1'b1);
    chk("t3_idle", 32'(bus.gnt_valid), 32'd0);

    // 4: forced release after MAX_HOLD cycles
    step(8'b0010_0000, 1'b1, 1'b0);
    chk("t4_gnt5", 32'(bus.gnt), 32'h20);
    for (int i = 0; i < MAX_HOLD - 1; i++) step(8'h00, 1'b1, 1'b0);
    chk("t4_still_held", 32'(bus.gnt), 32'h20);
    chk("t4_no_early_to", 32'(bus.timeout), 32'd0);
    step(8'h00, 1'b1, 1'b0);
    chk("t4_timeout", 32'(bus.timeout), 32'd1);
    chk("t4_ptr", 32'(bus.ptr), 32'd4);
    chk("t4_released", 32'(bus.gnt), 32'h00);
    step(8'h00, 1'b0, 1'b0);
    chk("t4_pulse_end", 32'(bus.timeout), 32'd0);
    // done on the limit cycle is a normal release
    step(8'b0010_0000, 1'b1, 1'b0);
    for (int i = 0; i < MAX_HOLD - 1; i++) step(8'h00, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b1);
    chk("t4b_no_timeout", 32'(bus.timeout), 32'd0);
    chk("t4b_ptr", 32'(bus.ptr), 32'd4);
    chk("t4b_released", 32'(bus.gnt), 32'h00);

    // 5: grant survives req drop and en=0
    step(8'b0000_1000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 1'b0);
    chk("t5_held", 32'(bus.gnt), 32'h08);
    step(8'h00, 1'b0, 1'b1);
    chk("t5_idle_gnt", 32'(bus.gnt), 32'h00);
    chk("t5_idle_vld", 32'(bus.gnt_valid), 32'd0);
    chk("t5_ptr", 32'(bus.ptr), 32'd2);
    step(8'h00, 1'b1, 1'b1);
    chk("t5_done_idle_ignored", 32'(bus.ptr), 32'd2);

    // contention: all request, rotation visible through the scoreboard
    for (int i = 0; i < 10; i++) step(8'hFF, 1'b1, 1'b1);

    // 6: asynchronous reset between edges mid-LOCK
    step(8'b0000_1000, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_gnt", 32'(bus.gnt), 32'h00);
    chk("t6_vld", 32'(bus.gnt_valid), 32'd0);
    chk("t6_ptr", 32'(bus.ptr), 32'd7);
    chk("t6_idx", 32'(bus.gnt_idx), 32'd0);
    model_reset();
    #2;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // random soak
    for (int i = 0; i < 400; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = 8'h00;
      step(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 3));
    end

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
